// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encodings and
// the load-use hazard detector.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } hz_state_e;

  // A load into x0 never creates a hazard; unused source fields are ignored.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic       use_rs1,
    input logic [4:0] rs2,
    input logic       use_rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch redirects, data-memory
// wait freeze, halt, and a saturating count of fetch-stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_inc_pc,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_redirect,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_halt,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic [31:0]      o_next_pc,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_pipe_freeze,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt
);

  hz_state_e        state_q, state_d;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lu_hit, mem_block;

  assign lu_hit = load_use_hit(i_ex_mem_read, i_ex_rd, i_id_rs1, i_id_use_rs1,
                               i_id_rs2, i_id_use_rs2);
  // In MEM_WAIT the access is already outstanding, so only the ack matters.
  assign mem_block = (state_q == ST_MEM_WAIT) ? !i_mem_ack : (i_mem_req && !i_mem_ack);

  always_comb begin
    state_d       = state_q;
    o_next_pc     = i_inc_pc;
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_pipe_freeze = 1'b0;
    o_halted      = 1'b0;
    if (i_rst) begin
      state_d   = ST_RUN;
      o_next_pc = RESET_PC;
    end else if (state_q == ST_HALT) begin
      o_next_pc    = pc_q;
      o_pc_stall   = 1'b1;
      o_ifid_stall = 1'b1;
      o_idex_flush = 1'b1;
      o_halted     = 1'b1;
    end else if (mem_block) begin
      state_d       = ST_MEM_WAIT;
      o_pipe_freeze = 1'b1;
      o_pc_stall    = 1'b1;
    end else begin
      state_d = ST_RUN;
      if (i_ex_halt) begin
        state_d      = ST_HALT;
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
      end else if (i_ex_redirect) begin
        o_next_pc    = i_ex_target;
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
      end else if (lu_hit) begin
        o_pc_stall   = 1'b1;
        o_ifid_stall = 1'b1;
        o_idex_flush = 1'b1;
      end
    end
  end

  // pc_q tracks the PC presented each cycle so HALT can freeze the last one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= o_next_pc;
      if (o_pc_stall && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RUN-state vector table plus hand-written
// sequences for memory wait, halt, reset and counter saturation.
module tb_hazard_ctrl;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inc_pc, ex_target;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        use1, use2, mem_read, redirect, halt, mem_req, mem_ack;

  logic [31:0] next_pc, next_pc4;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush, freeze, halted;
  logic        pc_stall4, ifid_stall4, ifid_flush4, idex_flush4, freeze4, halted4;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_inc_pc(inc_pc), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_rd(ex_rd), .i_ex_mem_read(mem_read),
    .i_ex_redirect(redirect), .i_ex_target(ex_target), .i_ex_halt(halt),
    .i_mem_req(mem_req), .i_mem_ack(mem_ack), .o_next_pc(next_pc), .o_pc_stall(pc_stall),
    .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
    .o_pipe_freeze(freeze), .o_halted(halted), .o_stall_cnt(cnt));

  hazard_ctrl #(.RESET_PC(RPC), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_inc_pc(inc_pc), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_rd(ex_rd), .i_ex_mem_read(mem_read),
    .i_ex_redirect(redirect), .i_ex_target(ex_target), .i_ex_halt(halt),
    .i_mem_req(mem_req), .i_mem_ack(mem_ack), .o_next_pc(next_pc4), .o_pc_stall(pc_stall4),
    .o_ifid_stall(ifid_stall4), .o_ifid_flush(ifid_flush4), .o_idex_flush(idex_flush4),
    .o_pipe_freeze(freeze4), .o_halted(halted4), .o_stall_cnt(cnt4));

  typedef struct {
    string       name;
    logic [31:0] inc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mrd, redir;
    logic [31:0] tgt;
    logic        mreq, mack;
    logic [31:0] e_pc;
    logic        e_pcs, e_ifs, e_iff, e_idf;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    inc_pc = 32'h0; ex_target = 32'h0; rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; mem_read = 1'b0; redirect = 1'b0; halt = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic set_lu();
    ex_rd = 5'd5; mem_read = 1'b1; rs1 = 5'd5; use1 = 1'b1; rs2 = 5'd1; use2 = 1'b1;
  endtask

  initial begin
    vt[0] = '{"idle",       32'h104, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 32'h104, 0, 0, 0, 0};
    vt[1] = '{"lu_rs1",     32'h108, 5, 1, 5, 1, 1, 1, 0, 0,      0, 0, 32'h108, 1, 1, 0, 1};
    vt[2] = '{"lw_x0",      32'h10c, 0, 0, 0, 1, 1, 1, 0, 0,      0, 0, 32'h10c, 0, 0, 0, 0};
    vt[3] = '{"rs2_unused", 32'h110, 1, 7, 7, 1, 0, 1, 0, 0,      0, 0, 32'h110, 0, 0, 0, 0};
    vt[4] = '{"lu_rs2",     32'h114, 1, 7, 7, 1, 1, 1, 0, 0,      0, 0, 32'h114, 1, 1, 0, 1};
    vt[5] = '{"redir_lu",   32'h118, 5, 1, 5, 1, 1, 1, 1, 32'h40, 0, 0, 32'h40,  0, 0, 1, 1};
    vt[6] = '{"redir",      32'h11c, 0, 0, 0, 0, 0, 0, 1, 32'h200,0, 0, 32'h200, 0, 0, 1, 1};
    vt[7] = '{"ack_lu",     32'h120, 5, 1, 5, 1, 1, 1, 0, 0,      1, 1, 32'h120, 1, 1, 0, 1};
    vt[8] = '{"no_load",    32'h124, 5, 1, 5, 1, 1, 0, 0, 0,      0, 0, 32'h124, 0, 0, 0, 0};

    clr(); rst = 1'b1;
    // Reset: outputs forced regardless of inputs
    @(negedge clk); inc_pc = 32'h1234; set_lu(); redirect = 1'b1; ex_target = 32'h80;
    #1;
    chk("rst_pc", next_pc, RPC);
    chk("rst_stall", {pc_stall, ifid_stall, ifid_flush, idex_flush, freeze, halted}, 0);
    @(negedge clk); #1;
    chk("rst_cnt", cnt, 0);

    // Single load-use bubble
    @(negedge clk); rst = 1'b0; clr(); inc_pc = 32'h8; set_lu(); #1;
    chk("lu1_stalls", {pc_stall, ifid_stall, idex_flush, ifid_flush}, 4'b1110);
    chk("lu1_pc", next_pc, 32'h8);
    @(negedge clk); clr(); inc_pc = 32'hc; #1;
    chk("lu1_after", {pc_stall, ifid_stall, idex_flush}, 0);
    chk("lu1_cnt", cnt, 1);
    exp_cnt = 1;

    // RUN-state vector table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      inc_pc = vt[i].inc; rs1 = vt[i].rs1; rs2 = vt[i].rs2; ex_rd = vt[i].rd;
      use1 = vt[i].u1; use2 = vt[i].u2; mem_read = vt[i].mrd; redirect = vt[i].redir;
      ex_target = vt[i].tgt; mem_req = vt[i].mreq; mem_ack = vt[i].mack;
      #1;
      chk({vt[i].name, "_pc"}, next_pc, vt[i].e_pc);
      chk({vt[i].name, "_ctl"}, {pc_stall, ifid_stall, ifid_flush, idex_flush, freeze},
          {vt[i].e_pcs, vt[i].e_ifs, vt[i].e_iff, vt[i].e_idf, 1'b0});
      if (vt[i].e_pcs) exp_cnt++;
    end
    @(negedge clk); clr(); #1;
    chk("table_cnt", cnt, exp_cnt);

    // Memory wait, ack 3 cycles after request, redirect held throughout
    do_reset();
    mem_req = 1'b1; redirect = 1'b1; ex_target = 32'h80; inc_pc = 32'h300;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("mw_freeze", {freeze, pc_stall, ifid_flush, idex_flush, ifid_stall}, 5'b11000);
      @(negedge clk); mem_req = 1'b0;
    end
    mem_ack = 1'b1; #1;
    chk("mw_ack_freeze", freeze, 0);
    chk("mw_ack_pc", next_pc, 32'h80);
    chk("mw_ack_flush", {ifid_flush, idex_flush, pc_stall}, 3'b110);
    @(negedge clk); clr(); #1;
    chk("mw_cnt", cnt, 3);

    // Halt: priority over redirect/load-use, PC frozen until reset
    do_reset();
    inc_pc = 32'h500; halt = 1'b1; redirect = 1'b1; ex_target = 32'h700; set_lu(); #1;
    chk("halt_entry_ctl", {ifid_flush, idex_flush, halted, pc_stall}, 4'b1100);
    chk("halt_entry_pc", next_pc, 32'h500);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); halt = 1'b0; inc_pc = 32'h600 + c; #1;
      chk("halt_ctl", {halted, pc_stall, ifid_stall, idex_flush, ifid_flush}, 5'b11110);
      chk("halt_pc", next_pc, 32'h500);
    end
    @(negedge clk); clr(); inc_pc = 32'h900; rst = 1'b1; #1;
    chk("halt_rst_pc", next_pc, RPC);
    chk("halt_rst_ctl", {halted, pc_stall, ifid_stall, idex_flush}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("halt_exit", {halted, pc_stall}, 0);
    chk("halt_exit_pc", next_pc, 32'h900);

    // Reset in the middle of a memory wait leaves no freeze behind
    @(negedge clk); mem_req = 1'b1; #1;
    chk("mwr_freeze", freeze, 1);
    @(negedge clk); mem_req = 1'b0; #1;
    chk("mwr_wait", freeze, 1);
    @(negedge clk); rst = 1'b1; #1;
    chk("mwr_rst", {freeze, pc_stall}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mwr_after", {freeze, pc_stall}, 0);

    // Saturation: 20 stall cycles on the 4-bit counter instance
    do_reset();
    set_lu();
    repeat (20) @(negedge clk);
    clr(); #1;
    chk("sat_cnt4", cnt4, 4'hF);
    chk("sat_cnt32", cnt, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
